// File: rtl/thermo_expand_if.sv
// thermo_expand_if: count-in / thermometer-out valid-ready handshake bundle
interface thermo_expand_if #(
  parameter int DATA_W = 10,
  parameter int POS_W  = $clog2(DATA_W + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [POS_W-1:0]  in_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/thermo_expand.sv
// thermo_expand: serial count-to-thermometer expander with saturation flag
module thermo_expand #(
  parameter int DATA_W = 10,
  parameter int POS_W  = $clog2(DATA_W + 1)
) (
  input logic            clk,
  input logic            rst,
  thermo_expand_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;
  state_t            r_state;
  state_t            w_next;
  logic [POS_W-1:0]  r_rem;
  logic [POS_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sr;
  logic              r_sat;
  logic              w_accept;
  logic              w_last;
  logic              w_over;
  assign w_accept      = (r_state == IDLE) && bus.in_valid;
  assign w_last        = r_idx == POS_W'(DATA_W - 1);
  assign w_over        = bus.in_count > POS_W'(DATA_W);
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.out_data  = bus.out_valid ? r_sr : '0;
  assign bus.out_sat   = bus.out_valid & r_sat;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state: accept in IDLE, fixed-length build, hold result until taken
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)  ? (w_accept ? BUILD : IDLE) :
             (r_state == BUILD) ? (w_last ? DONE : BUILD) :
             (r_state == DONE)  ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  // datapath: latch clamped count, then shift ones in from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_idx <= '0;
      r_sr  <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_rem <= w_over ? POS_W'(DATA_W) : bus.in_count;
      r_sat <= w_over;
      r_idx <= '0;
      r_sr  <= '0;
    end else if (r_state == BUILD) begin
      r_sr  <= {r_rem != '0, r_sr[DATA_W-1:1]};
      r_rem <= r_rem - POS_W'(r_rem != '0);
      r_idx <= r_idx + POS_W'(1);
    end
  end
endmodule

// File: tb/tb_thermo_expand.sv
// tb_thermo_expand: table, hand sequences and random checks against a count model
module tb_thermo_expand;
  localparam int DW = 10;
  localparam int LAT = DW + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  thermo_expand_if #(.DATA_W(DW)) bus ();
  thermo_expand #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int         cnt;
    logic [9:0] data;
    logic       sat;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] model_data(input int c);
    logic [9:0] v = '0;
    for (int i = 0; i < DW; i++) if (i < c) v[i] = 1'b1;
    return v;
  endfunction
  task automatic transact(input int cnt, input int hold, input bit noise,
                          output logic [9:0] d, output logic s, output int lat);
    int n;
    chk("ready_before", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_count = 4'(cnt);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      chk("ready_build", 32'(bus.in_ready), 0);
      chk("data_gated", 32'({bus.out_sat, bus.out_data}), 0);
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.in_count = 4'($urandom);
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    d = bus.out_data;
    s = bus.out_sat;
    n = 0;
    while (n < hold) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_ready", 32'(bus.in_ready), 0);
      chk("hold_data", 32'({bus.out_sat, bus.out_data}), 32'({s, d}));
      tick();
      n++;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ready_after", 32'(bus.in_ready), 1);
    chk("valid_after", 32'(bus.out_valid), 0);
  endtask
  task automatic check_txn(input string tag, input int cnt, input logic [9:0] ed,
                           input logic es, input int hold, input bit noise);
    logic [9:0] d;
    logic s;
    int lat;
    transact(cnt, hold, noise, d, s, lat);
    chk({tag, "_lat"}, 32'(lat), LAT);
    chk({tag, "_data"}, 32'(d), 32'(ed));
    chk({tag, "_sat"}, 32'(s), 32'(es));
    chk({tag, "_pop"}, 32'($countones(d)), 32'(cnt > DW ? DW : cnt));
  endtask
  task automatic no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    chk(tag, 32'(seen), 0);
  endtask
  initial begin
    int c;
    int w;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    bus.out_ready = 1'b0;
    tbl[0] = '{3,  10'h007, 1'b0};
    tbl[1] = '{0,  10'h000, 1'b0};
    tbl[2] = '{10, 10'h3FF, 1'b0};
    tbl[3] = '{15, 10'h3FF, 1'b1};
    tbl[4] = '{1,  10'h001, 1'b0};
    tbl[5] = '{9,  10'h1FF, 1'b0};
    tbl[6] = '{11, 10'h3FF, 1'b1};
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_out", 32'({bus.out_sat, bus.out_data}), 0);
    for (int i = 0; i < 7; i++) check_txn("tbl", tbl[i].cnt, tbl[i].data, tbl[i].sat, 0, 0);
    check_txn("hold7", 7, 10'h07F, 1'b0, 20, 0);
    check_txn("noise4", 4, 10'h00F, 1'b0, 2, 1);
    for (int i = 0; i < 16; i++) check_txn("exh", i, model_data(i), i > DW, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_count = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(bus.in_ready), 1);
    chk("abort_out", 32'({bus.out_valid, bus.out_sat, bus.out_data}), 0);
    no_valid("abort_novalid", 20);
    bus.in_valid = 1'b1;
    bus.in_count = 4'd9;
    tick();
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 50) begin
      tick();
      w++;
    end
    chk("done_reached", 32'(bus.out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_abort", 32'({bus.out_valid, bus.out_sat, bus.out_data}), 0);
    chk("done_abort_ready", 32'(bus.in_ready), 1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_count = 4'd6;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_accept_ready", 32'(bus.in_ready), 1);
    no_valid("rst_accept_novalid", 15);
    for (int i = 0; i < 30; i++) begin
      c = int'($urandom_range(15, 0));
      check_txn("rnd", c, model_data(c), c > DW, int'($urandom_range(3, 0)), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thermo_expand.md
THERMO_EXPAND -- requirements
Module: thermo_expand

Interface
REQ-001 Parameter DATA_W, default 10, SHALL set the output vector width in bits.
REQ-002 Parameter POS_W, default $clog2(DATA_W+1), SHALL set the count input width and SHALL be able to represent DATA_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL mark in_count as valid.
REQ-006 in_ready  output  1  SHALL indicate the block can accept a count.
REQ-007 in_count  input  POS_W  SHALL give the number of ones to generate.
REQ-008 out_valid  output  1  SHALL mark out_data/out_sat as valid.
REQ-009 out_ready  input  1  SHALL indicate the consumer accepts the result.
REQ-010 out_data  output  DATA_W  SHALL hold the thermometer vector: exactly min(in_count, DATA_W) low-order bits set, all others clear.
REQ-011 out_sat  output  1  SHALL flag that the accepted in_count exceeded DATA_W.

Function
REQ-012 The block SHALL be the inverse of the team's ones-count block: popcount(out_data) SHALL equal min(in_count, DATA_W).
REQ-013 FSM states SHALL be IDLE, BUILD and DONE; no other states are reachable.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch rem=min(in_count,DATA_W), sat=(in_count>DATA_W), clear the shift register and bit index, go to BUILD.
REQ-015 BUILD: in_ready=0, out_valid=0; each cycle shift the register right by one, inserting 1 at bit DATA_W-1 if rem>0 (then rem decrements), else 0.
REQ-016 BUILD SHALL last exactly DATA_W cycles, tracked by a bit index counting 0..DATA_W-1, then go to DONE; the first-inserted bit lands in bit 0.
REQ-017 DONE: in_ready=0, out_valid=1; out_data and out_sat SHALL stay stable until out_ready is sampled high, then the FSM goes to IDLE.
REQ-018 Latency: out_valid SHALL first be high exactly DATA_W+1 cycles after the input handshake cycle, independent of in_count.
REQ-019 Throughput: a new input SHALL be accepted no earlier than the cycle after the output handshake; no bypass or overlap.
REQ-020 out_data and out_sat SHALL read 0 whenever out_valid is 0.
REQ-021 in_count=0 SHALL produce out_data all zeros, out_sat=0.
REQ-022 in_count=DATA_W SHALL produce all ones, out_sat=0; in_count>DATA_W SHALL produce all ones, out_sat=1.
REQ-023 in_valid while in_ready=0 SHALL be ignored; in_count changes during BUILD/DONE SHALL not affect the result.
REQ-024 out_valid held with out_ready=0 SHALL persist indefinitely without data change.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, clear rem, sat, bit index and shift register, in any state.
REQ-026 In the cycle after reset: in_ready=1, out_valid=0, out_data=0, out_sat=0.
REQ-027 Reset during BUILD or DONE SHALL abort the operation; no out_valid pulse for the aborted count.
REQ-028 An in_valid coincident with rst high SHALL not be accepted.

Verification
REQ-029 DATA_W=10: in_count=3 accepted at cycle 0 -> out_valid first high at cycle 11, out_data=0x007, out_sat=0.
REQ-030 in_count=0, then 10, then 15 back-to-back with out_ready=1 -> out_data 0x000/0x3FF/0x3FF, out_sat 0/0/1, each 11 cycles after its accept.
REQ-031 in_count=7, out_ready=0 for 20 cycles after out_valid -> out_data=0x07F stable, in_ready=0 throughout; accept on out_ready=1, in_ready=1 next cycle.
REQ-032 rst pulse 4 cycles after accepting in_count=5 -> no out_valid; in_ready=1 and all outputs 0 the cycle after rst.
REQ-033 Exhaustive in_count 0..15 fed through the ones-count block -> count equals min(in_count,10) for every value.
REQ-034 in_valid toggled with random in_count during BUILD -> ignored; result matches the originally accepted count.
